// File: rtl/pixel_streamer.sv
// pixel_streamer: frame source for the convolution front end.
//
// Holds one W x H 8-bit image in a register array that is loaded through a
// simple write port. On start it replays the image in raster order as a
// valid/ready stream, with first/last framing and a one-cycle done pulse.
//
// Optional feature macro: PIXEL_STREAMER_PAD_EN
//   Defined:   stream is (W+2) x (H+2) with a zero border for "same"
//              convolution.
//   Undefined: exactly W x H pixels.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   wr_en        frame-memory write strobe (honoured in IDLE only)
//   wr_addr      row-major write index row*W + col
//   wr_data      pixel to store
//   start        begin streaming a frame (level-sampled in IDLE)
//   pixel_ready  downstream accepts the current pixel
//   pixel_out    current pixel
//   pixel_valid  pixel_out is valid
//   first_pixel  current pixel is frame position (0,0)
//   last_pixel   current pixel is the final frame position
//   busy         a frame is in progress
//   done         one-cycle pulse after the last pixel is accepted
module pixel_streamer #(
  parameter int unsigned W  = 5,
  parameter int unsigned H  = 5,
  parameter int unsigned AW = $clog2(W * H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          start,
  input  logic          pixel_ready,
  output logic [7:0]    pixel_out,
  output logic          pixel_valid,
  output logic          first_pixel,
  output logic          last_pixel,
  output logic          busy,
  output logic          done
);

`ifdef PIXEL_STREAMER_PAD_EN
  localparam int unsigned SW = W + 2;
  localparam int unsigned SH = H + 2;
`else
  localparam int unsigned SW = W;
  localparam int unsigned SH = H;
`endif
  localparam int unsigned Depth = W * H;
  localparam int unsigned CW    = $clog2(SW);
  localparam int unsigned RW    = $clog2(SH);
  localparam logic [CW-1:0] ColMax = CW'(SW - 1);
  localparam logic [RW-1:0] RowMax = RW'(SH - 1);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e        state_q;
  logic [7:0]    mem_q [Depth];
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [7:0]    pixel_q;
  logic          valid_q, first_q, last_q, busy_q, done_q;

  logic [RW-1:0] row_nxt;
  logic [CW-1:0] col_nxt;
  logic          nxt_last;
  logic [7:0]    nxt_pix;
  logic [7:0]    first_pix;
  logic          wr_ok;

  // Next raster position and the pixel that lives there, so the output
  // register can be refilled on the same edge that accepts the current pixel.
  always_comb begin
    row_nxt = row_q;
    col_nxt = col_q + 1'b1;
    if (col_q == ColMax) begin
      col_nxt = '0;
      row_nxt = row_q + 1'b1;
    end
    nxt_last = (row_nxt == RowMax) && (col_nxt == ColMax);
`ifdef PIXEL_STREAMER_PAD_EN
    nxt_pix = 8'd0;
    if (row_nxt != '0 && row_nxt != RowMax && col_nxt != '0 && col_nxt != ColMax) begin
      nxt_pix = mem_q[AW'((32'(row_nxt) - 1) * W + 32'(col_nxt) - 1)];
    end
`else
    nxt_pix = mem_q[AW'(32'(row_nxt) * W + 32'(col_nxt))];
`endif
  end

  assign wr_ok = wr_en && (state_q == StIdle) && (32'(wr_addr) < Depth);

  // Write-first: a same-cycle write to address 0 is what (0,0) must show.
`ifdef PIXEL_STREAMER_PAD_EN
  assign first_pix = 8'd0;
`else
  assign first_pix = (wr_ok && wr_addr == '0) ? wr_data : mem_q[0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= 8'd0;
      row_q   <= '0;
      col_q   <= '0;
      pixel_q <= 8'd0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (wr_ok) mem_q[wr_addr] <= wr_data;
          if (start) begin
            state_q <= StStream;
            row_q   <= '0;
            col_q   <= '0;
            pixel_q <= first_pix;
            valid_q <= 1'b1;
            first_q <= 1'b1;
            last_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StStream: begin
          if (pixel_ready) begin
            if (last_q) begin
              state_q <= StDone;
              pixel_q <= 8'd0;
              valid_q <= 1'b0;
              first_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              row_q   <= row_nxt;
              col_q   <= col_nxt;
              pixel_q <= nxt_pix;
              first_q <= 1'b0;
              last_q  <= nxt_last;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pixel_out   = pixel_q;
  assign pixel_valid = valid_q;
  assign first_pixel = first_q;
  assign last_pixel  = last_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_pixel_streamer.sv
// Directed self-checking bench for pixel_streamer (W = H = 5).
module tb_pixel_streamer;

`ifdef PIXEL_STREAMER_PAD_EN
  localparam int N  = 49;
  localparam bit Pad = 1'b1;
`else
  localparam int N  = 25;
  localparam bit Pad = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       pixel_ready = 1'b0;
  logic [7:0] pixel_out;
  logic       pixel_valid, first_pixel, last_pixel, busy, done;

  int checks = 0;
  int failures = 0;

  pixel_streamer #(.W(5), .H(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .pixel_ready (pixel_ready),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .first_pixel (first_pixel),
    .last_pixel  (last_pixel),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected stream value at raster index idx for the ramp image 1..25.
  function automatic logic [7:0] exp_pix(input int idx, input bit zeros);
    int r, c;
    if (zeros) return 8'd0;
    if (Pad) begin
      r = idx / 7;
      c = idx % 7;
      if (r == 0 || r == 6 || c == 0 || c == 6) return 8'd0;
      return 8'((r - 1) * 5 + (c - 1) + 1);
    end
    return 8'(idx + 1);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, " pixel_out"}, 32'(pixel_out), 0);
    chk({tag, " valid"}, 32'(pixel_valid), 0);
    chk({tag, " first"}, 32'(first_pixel), 0);
    chk({tag, " last"}, 32'(last_pixel), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 25; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 8'(i + 1);
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Streams one frame and checks every cycle, the done pulse and the IDLE
  // cycle that follows. stall uses ready pattern 1,0,0,1,0,0...; poke tries a
  // write to address 3 plus a start while the second pixel is on the output.
  task automatic run_frame(input string tag, input bit launch, input bit stall,
                           input bit zeros, input bit poke, input bit hold);
    int idx = 0;
    int cyc = 0;
    bit poked = 1'b0;
    bit rdy;
    if (launch) begin
      start = 1'b1;
      tick();
      start = hold;
    end
    while (idx < N && cyc < 4 * N) begin
      chk({tag, " valid"}, 32'(pixel_valid), 1);
      chk({tag, " pixel"}, 32'(pixel_out), 32'(exp_pix(idx, zeros)));
      chk({tag, " first"}, 32'(first_pixel), 32'(idx == 0));
      chk({tag, " last"}, 32'(last_pixel), 32'(idx == N - 1));
      chk({tag, " busy"}, 32'(busy), 1);
      chk({tag, " done_early"}, 32'(done), 0);
      rdy = stall ? (cyc % 3 == 0) : 1'b1;
      pixel_ready = rdy;
      if (poke && idx == 1 && !poked) begin
        poked = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 8'hFF; start = 1'b1;
      end
      tick();
      wr_en = 1'b0;
      start = hold;
      if (rdy) idx++;
      cyc++;
    end
    chk({tag, " accepted"}, 32'(idx), 32'(N));
    chk({tag, " cycles"}, 32'(cyc), stall ? 32'(3 * (N - 1) + 1) : 32'(N));
    chk({tag, " done"}, 32'(done), 1);
    chk({tag, " done_valid"}, 32'(pixel_valid), 0);
    chk({tag, " done_busy"}, 32'(busy), 1);
    tick();
    chk({tag, " idle_done"}, 32'(done), 0);
    chk({tag, " idle_busy"}, 32'(busy), 0);
    chk({tag, " idle_valid"}, 32'(pixel_valid), 0);
  endtask

  initial begin
    int guard;
    bit seen;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    load_ramp();
    run_frame("plain", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("stall", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame("poke", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Out-of-range write in IDLE must not disturb the image
    wr_en = 1'b1; wr_addr = 5'd25; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    run_frame("oob", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Write and start in the same IDLE cycle: write-first for (0,0)
    pixel_ready = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'h77; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk("wfirst pixel", 32'(pixel_out), Pad ? 32'h0 : 32'h77);
    chk("wfirst first", 32'(first_pixel), 1);
    pixel_ready = 1'b1;
    guard = 0;
    seen = 1'b0;
    while (!seen && guard < 200) begin
      tick();
      seen = done;
      guard++;
    end
    chk("wfirst done_seen", 32'(seen), 1);
    tick();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'd1;
    tick();
    wr_en = 1'b0;

    // start held high: back-to-back frames with one IDLE cycle between
    run_frame("hold1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("hold relaunch valid", 32'(pixel_valid), 1);
    chk("hold relaunch first", 32'(first_pixel), 1);
    start = 1'b0;
    run_frame("hold2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset after the 10th accepted pixel aborts with no done
    pixel_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("midrst pre_valid", 32'(pixel_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("midrst");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst no_done", 32'(done), 0);
      chk("midrst no_valid", 32'(pixel_valid), 0);
    end
    run_frame("zeros", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
